register_pipe: RTL and testbench



---
 rtl/register_pipe.sv | 94 +++++++++
 tb/tb_register_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_pipe.sv
// register_pipe: WIDTH-bit, DEPTH-stage register pipeline with per-stage valid
// tracking, global clock enable, flush and a registered occupancy count.
//
// Optional feature macro: REGISTER_PIPE_TAPS_EN
//   When defined, TAPS and TAP_VALID expose every stage directly from the flops.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RESET      synchronous active-high reset (priority over FLUSH and CE)
//   CE         clock enable, the pipeline advances only when 1
//   FLUSH      synchronous clear of all valid bits (data is kept)
//   I          data in
//   I_VALID    qualifies I
//   O          data out of the final stage
//   O_VALID    valid bit of the final stage
//   COUNT      number of stages currently holding valid data
//   TAPS       {d[DEPTH-1],...,d[0]}  (REGISTER_PIPE_TAPS_EN only)
//   TAP_VALID  {v[DEPTH-1],...,v[0]}  (REGISTER_PIPE_TAPS_EN only)
module register_pipe #(
  parameter int unsigned      WIDTH = 3,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CE,
  input  logic                        FLUSH,
  input  logic [WIDTH-1:0]            I,
  input  logic                        I_VALID,
  output logic [WIDTH-1:0]            O,
  output logic                        O_VALID,
`ifdef REGISTER_PIPE_TAPS_EN
  output logic [WIDTH*DEPTH-1:0]      TAPS,
  output logic [DEPTH-1:0]            TAP_VALID,
`endif
  output logic [$clog2(DEPTH+1)-1:0]  COUNT
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Stage 0 sits in the LSBs so the packed vector doubles as the tap bus.
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            v;
  logic [CW-1:0]               count;

  logic enter_c;
  logic leave_c;

  // A word only enters when it is actually captured; FLUSH suppresses it.
  assign enter_c = CE & I_VALID & ~FLUSH;
  assign leave_c = CE & v[DEPTH-1];

  // Data and valid shift register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d[k] <= INIT;
      end
      v <= '0;
    end else begin
      if (CE) begin
        d[0] <= I;
        v[0] <= I_VALID;
        for (int unsigned k = 1; k < DEPTH; k++) begin
          d[k] <= d[k-1];
          v[k] <= v[k-1];
        end
      end
      // FLUSH overrides the shift, including the bit capturing I_VALID.
      if (FLUSH) begin
        v <= '0;
      end
    end
  end

  // Occupancy tracked incrementally so it stays in step with v[].
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      count <= '0;
    end else begin
      count <= count + CW'(enter_c) - CW'(leave_c);
    end
  end

  assign O       = d[DEPTH-1];
  assign O_VALID = v[DEPTH-1];
  assign COUNT   = count;

`ifdef REGISTER_PIPE_TAPS_EN
  assign TAPS      = d;
  assign TAP_VALID = v;
`endif

endmodule

// File: tb/tb_register_pipe.sv
// Directed self-checking bench for register_pipe. Four instances share one
// stimulus bus: DEPTH=1, 2, 3 and 4, all WIDTH=3, INIT=3'b101.
module tb_register_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       flush;
  logic [2:0] din;
  logic       din_valid;

  logic [2:0] o1, o2, o3, o4;
  logic       ov1, ov2, ov3, ov4;
  logic [0:0] c1;
  logic [1:0] c2;
  logic [1:0] c3;
  logic [2:0] c4;

`ifdef REGISTER_PIPE_TAPS_EN
  logic [2:0]  taps1;
  logic [0:0]  tv1;
  logic [5:0]  taps2;
  logic [1:0]  tv2;
  logic [8:0]  taps3;
  logic [2:0]  tv3;
  logic [11:0] taps4;
  logic [3:0]  tv4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_pipe #(.WIDTH(3), .DEPTH(1), .INIT(3'b101)) u_d1 (
    .CLK(clk), .RESET(reset), .CE(ce), .FLUSH(flush), .I(din), .I_VALID(din_valid),
    .O(o1), .O_VALID(ov1),
`ifdef REGISTER_PIPE_TAPS_EN
    .TAPS(taps1), .TAP_VALID(tv1),
`endif
    .COUNT(c1));

  register_pipe #(.WIDTH(3), .DEPTH(2), .INIT(3'b101)) u_d2 (
    .CLK(clk), .RESET(reset), .CE(ce), .FLUSH(flush), .I(din), .I_VALID(din_valid),
    .O(o2), .O_VALID(ov2),
`ifdef REGISTER_PIPE_TAPS_EN
    .TAPS(taps2), .TAP_VALID(tv2),
`endif
    .COUNT(c2));

  register_pipe #(.WIDTH(3), .DEPTH(3), .INIT(3'b101)) u_d3 (
    .CLK(clk), .RESET(reset), .CE(ce), .FLUSH(flush), .I(din), .I_VALID(din_valid),
    .O(o3), .O_VALID(ov3),
`ifdef REGISTER_PIPE_TAPS_EN
    .TAPS(taps3), .TAP_VALID(tv3),
`endif
    .COUNT(c3));

  register_pipe #(.WIDTH(3), .DEPTH(4), .INIT(3'b101)) u_d4 (
    .CLK(clk), .RESET(reset), .CE(ce), .FLUSH(flush), .I(din), .I_VALID(din_valid),
    .O(o4), .O_VALID(ov4),
`ifdef REGISTER_PIPE_TAPS_EN
    .TAPS(taps4), .TAP_VALID(tv4),
`endif
    .COUNT(c4));

  // One rising edge, then settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic f,
                       input logic [2:0] data, input logic dv);
    reset     = r;
    ce        = e;
    flush     = f;
    din       = data;
    din_valid = dv;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    step();
    checks++; if (o2 !== 3'b101) begin errors++; $display("FAIL reset_o got=%b want=101", o2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b want=0", ov2); end
    checks++; if (c2 !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", c2); end
    checks++; if (o4 !== 3'b101) begin errors++; $display("FAIL reset_o_d4 got=%b want=101", o4); end
    // RESET wins over CE with valid input
    drive(1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
    step();
    checks++; if (o2 !== 3'b101) begin errors++; $display("FAIL reset_hold_o got=%b want=101", o2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_hold_ovalid got=%b want=0", ov2); end
    checks++; if (c2 !== 2'd0) begin errors++; $display("FAIL reset_hold_count got=%0d want=0", c2); end
    step();
    checks++; if (o2 !== 3'b101) begin errors++; $display("FAIL reset_hold2_o got=%b want=101", o2); end
  endtask

  task automatic test_latency();
    drive(1'b0, 1'b1, 1'b0, 3'b011, 1'b1);
    step();
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL lat_e1_ovalid got=%b want=0", ov2); end
    checks++; if (c2 !== 2'd1) begin errors++; $display("FAIL lat_e1_count got=%0d want=1", c2); end
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    step();
    checks++; if (o2 !== 3'b011) begin errors++; $display("FAIL lat_e2_o got=%b want=011", o2); end
    checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL lat_e2_ovalid got=%b want=1", ov2); end
    checks++; if (c2 !== 2'd1) begin errors++; $display("FAIL lat_e2_count got=%0d want=1", c2); end
    step();
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL lat_e3_ovalid got=%b want=0", ov2); end
    checks++; if (c2 !== 2'd0) begin errors++; $display("FAIL lat_e3_count got=%0d want=0", c2); end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b1, 1'b0, 3'd1, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b1);
    step();
    checks++; if (o2 !== 3'd1 || ov2 !== 1'b1) begin errors++; $display("FAIL stall_first got=%0d/%b want=1/1", o2, ov2); end
    // CE low: word 3 on the input must be ignored and outputs frozen
    drive(1'b0, 1'b0, 1'b0, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (o2 !== 3'd1 || ov2 !== 1'b1) begin errors++; $display("FAIL stall_frozen%0d got=%0d/%b want=1/1", i, o2, ov2); end
      checks++; if (c2 !== 2'd2) begin errors++; $display("FAIL stall_count%0d got=%0d want=2", i, c2); end
    end
    drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    step();
    checks++; if (o2 !== 3'd2 || ov2 !== 1'b1) begin errors++; $display("FAIL stall_second got=%0d/%b want=2/1", o2, ov2); end
    checks++; if (c2 !== 2'd2) begin errors++; $display("FAIL stall_full_count got=%0d want=2", c2); end
    drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step();
    checks++; if (o2 !== 3'd3 || ov2 !== 1'b1) begin errors++; $display("FAIL stall_third got=%0d/%b want=3/1", o2, ov2); end
    step();
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b want=0", ov2); end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(i), 1'b1);
      step();
    end
    checks++; if (c4 !== 3'd4) begin errors++; $display("FAIL flush_fill_count got=%0d want=4", c4); end
    checks++; if (o4 !== 3'd1 || ov4 !== 1'b1) begin errors++; $display("FAIL flush_fill_o got=%0d/%b want=1/1", o4, ov4); end
    drive(1'b0, 1'b1, 1'b1, 3'd7, 1'b1);
    step();
    checks++; if (c4 !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", c4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL flush_ovalid0 got=%b want=0", ov4); end
    checks++; if (o4 !== 3'd2) begin errors++; $display("FAIL flush_data_kept got=%0d want=2", o4); end
    drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (ov4 !== 1'b0 || c4 !== 3'd0) begin errors++; $display("FAIL flush_after%0d got=%b/%0d want=0/0", i, ov4, c4); end
    end
    checks++; if (o4 !== 3'd7) begin errors++; $display("FAIL flush_data7 got=%0d want=7", o4); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b1);
    step();
    checks++; if (c3 !== 2'd2) begin errors++; $display("FAIL mid_inflight_count got=%0d want=2", c3); end
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    step();
    checks++; if (o3 !== 3'b101 || ov3 !== 1'b0 || c3 !== 2'd0) begin errors++; $display("FAIL mid_reset got=%b/%b/%0d want=101/0/0", o3, ov3, c3); end
    drive(1'b0, 1'b1, 1'b0, 3'd4, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    step();
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL mid_early got=%b want=0", ov3); end
    step();
    checks++; if (o3 !== 3'd4 || ov3 !== 1'b1) begin errors++; $display("FAIL mid_emerge got=%0d/%b want=4/1", o3, ov3); end
  endtask

  task automatic test_depth1();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    checks++; if (o1 !== 3'b101 || ov1 !== 1'b0 || c1 !== 1'b0) begin errors++; $display("FAIL d1_reset got=%b/%b/%0d want=101/0/0", o1, ov1, c1); end
    drive(1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
    step();
    checks++; if (o1 !== 3'd6 || ov1 !== 1'b1 || c1 !== 1'b1) begin errors++; $display("FAIL d1_first got=%0d/%b/%0d want=6/1/1", o1, ov1, c1); end
    drive(1'b0, 1'b1, 1'b0, 3'd1, 1'b1);
    step();
    checks++; if (o1 !== 3'd1 || ov1 !== 1'b1 || c1 !== 1'b1) begin errors++; $display("FAIL d1_full got=%0d/%b/%0d want=1/1/1", o1, ov1, c1); end
    drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
    step();
    checks++; if (o1 !== 3'd1 || ov1 !== 1'b0 || c1 !== 1'b0) begin errors++; $display("FAIL d1_flush_hold got=%0d/%b/%0d want=1/0/0", o1, ov1, c1); end
  endtask

`ifdef REGISTER_PIPE_TAPS_EN
  task automatic test_taps();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(i), 1'b1);
      step();
    end
    checks++; if (taps3 !== 9'b001_010_011) begin errors++; $display("FAIL taps_data got=%b want=001010011", taps3); end
    checks++; if (tv3 !== 3'b111) begin errors++; $display("FAIL taps_valid got=%b want=111", tv3); end
  endtask
`endif

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_depth1();
`ifdef REGISTER_PIPE_TAPS_EN
    test_taps();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
